// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: datapath width, reset vector and the
// canonical NOP encoding (addi x0, x0, 0).
package riscv_pkg;

  localparam int              RV_XLEN     = 32;
  localparam int              RV_INSN_W   = 32;
  localparam logic [31:0]     RV_RESET_PC = 32'h0000_0000;
  localparam logic [31:0]     RV_NOP      = 32'h0000_0013;

  typedef logic [RV_INSN_W-1:0] insn_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and single-cycle flush.
// Push and pop may happen together, including when full.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, doPush, doPop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    doPop   = pop && !empty;
    doPush  = push && (!full || doPop);
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush) mem_q[wrPtr_q] <= wdata;
  end

  assign rdata = mem_q[rdPtr_q];
  assign count = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetches, tracks in-flight
// PCs, buffers returned words and discards stale beats after a redirect.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = RV_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = RV_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [XLEN-1:0]      imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [RV_INSN_W-1:0] imem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [RV_INSN_W-1:0] inst_data,
  output logic [XLEN-1:0]      inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = RV_INSN_W + XLEN;

  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  logic [CW-1:0]   dropCnt_q, dropCnt_d;
  logic [CW-1:0]   outCount, bufCount;
  logic [XLEN-1:0] oldestPc;
  logic [BW-1:0]   bufHead;
  logic            reqFire, bufPush, bufPop;
  logic            unusedRedirectLsb;

  assign unusedRedirectLsb = ^redirect_pc[1:0];

  // Every in-flight request reserves a buffer slot, so the buffer cannot overflow.
  assign imem_req_valid = !rst && !redirect_valid &&
                          (({1'b0, outCount} + {1'b0, bufCount}) < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetchPc_q;

  always_comb begin
    reqFire   = imem_req_valid && imem_req_ready;
    bufPush   = imem_rsp_valid && (dropCnt_q == '0) && !redirect_valid;
    bufPop    = inst_valid && inst_ready && !redirect_valid;
    fetchPc_d = fetchPc_q;
    dropCnt_d = dropCnt_q;
    if (redirect_valid) begin
      fetchPc_d = {redirect_pc[XLEN-1:2], 2'b00};
      // The beat arriving now is discarded by the flush; everything still in flight is stale.
      dropCnt_d = (imem_rsp_valid && (outCount != '0)) ? outCount - 1'b1 : outCount;
    end else begin
      if (reqFire) fetchPc_d = fetchPc_q + XLEN'(4);
      if (imem_rsp_valid && (dropCnt_q != '0)) dropCnt_d = dropCnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc_q <= RESET_PC;
      dropCnt_q <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_outstanding (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (reqFire),
    .wdata (fetchPc_q),
    .pop   (imem_rsp_valid),
    .rdata (oldestPc),
    .count (outCount)
  );

  fetch_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (bufPush),
    .wdata ({imem_rsp_data, oldestPc}),
    .pop   (bufPop),
    .rdata (bufHead),
    .count (bufCount)
  );

  assign inst_valid = (bufCount != '0);
  assign inst_data  = inst_valid ? bufHead[BW-1 -: RV_INSN_W] : '0;
  assign inst_pc    = inst_valid ? bufHead[XLEN-1:0] : '0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: a DEPTH=2 unit, a DEPTH=4
// unit and a DEPTH=4 unit whose reset vector sits just below the wrap point.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        aReqValid, aReqReady, aRspValid = 1'b0, aRedirValid, aInstValid, aInstReady, aHold;
  logic [31:0] aReqAddr, aRspData = '0, aRedirPc, aInstData, aInstPc;
  logic        bReqValid, bReqReady, bRspValid = 1'b0, bInstValid, bInstReady;
  logic [31:0] bReqAddr, bRspData = '0, bInstData, bInstPc;
  logic        wReqValid, wInstValid;
  logic [31:0] wReqAddr, wInstData, wInstPc;

  logic [31:0] aQ[$];
  logic [31:0] bQ[$];
  logic [31:0] gotPc[$];
  logic [31:0] gotData[$];

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dutA (
    .clk(clk), .rst(rst),
    .imem_req_valid(aReqValid), .imem_req_ready(aReqReady), .imem_req_addr(aReqAddr),
    .imem_rsp_valid(aRspValid), .imem_rsp_data(aRspData),
    .redirect_valid(aRedirValid), .redirect_pc(aRedirPc),
    .inst_valid(aInstValid), .inst_ready(aInstReady), .inst_data(aInstData), .inst_pc(aInstPc)
  );

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dutB (
    .clk(clk), .rst(rst),
    .imem_req_valid(bReqValid), .imem_req_ready(bReqReady), .imem_req_addr(bReqAddr),
    .imem_rsp_valid(bRspValid), .imem_rsp_data(bRspData),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(bInstValid), .inst_ready(bInstReady), .inst_data(bInstData), .inst_pc(bInstPc)
  );

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dutW (
    .clk(clk), .rst(rst),
    .imem_req_valid(wReqValid), .imem_req_ready(1'b1), .imem_req_addr(wReqAddr),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(wInstValid), .inst_ready(1'b0), .inst_data(wInstData), .inst_pc(wInstPc)
  );

  function automatic logic [31:0] memData(input logic [31:0] addr);
    return addr ^ 32'hDEAD_BEEF;
  endfunction

  // In-order memory with one-cycle latency; aHold stalls dutA's responses.
  always @(posedge clk) begin
    if (rst) begin
      aQ.delete();
      bQ.delete();
    end else begin
      if (aRspValid) void'(aQ.pop_front());
      if (aReqValid && aReqReady) aQ.push_back(aReqAddr);
      if (bRspValid) void'(bQ.pop_front());
      if (bReqValid && bReqReady) bQ.push_back(bReqAddr);
    end
    #1;
    if (!rst && (aQ.size() != 0) && !aHold) begin
      aRspValid = 1'b1;
      aRspData  = memData(aQ[0]);
    end else begin
      aRspValid = 1'b0;
      aRspData  = '0;
    end
    if (!rst && (bQ.size() != 0)) begin
      bRspValid = 1'b1;
      bRspData  = memData(bQ[0]);
    end else begin
      bRspValid = 1'b0;
      bRspData  = '0;
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst         = 1'b1;
    aRedirValid = 1'b0;
    aRedirPc    = '0;
    aReqReady   = 1'b1;
    bReqReady   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic collectInsts(input int n, input int budget);
    gotPc.delete();
    gotData.delete();
    for (int c = 0; (c < budget) && (gotPc.size() < n); c++) begin
      #1;
      if (aInstValid) begin
        gotPc.push_back(aInstPc);
        gotData.push_back(aInstData);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (aReqValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_req_valid: got %b, expected 0", aReqValid);
    end
    checks++;
    if (aInstValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_inst_valid: got %b, expected 0", aInstValid);
    end
    checks++;
    if ((aInstData !== 32'h0) || (aInstPc !== 32'h0)) begin
      errors++;
      $display("[TB] FAIL reset_inst_fields: got data=%h pc=%h, expected 0/0", aInstData, aInstPc);
    end
    bInstReady = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i < 3) begin
        checks++;
        if ((bReqValid !== 1'b1) || (bReqAddr !== 32'(i * 4))) begin
          errors++;
          $display("[TB] FAIL reset_seq_addr[%0d]: got valid=%b addr=%h, expected valid=1 addr=%h",
                   i, bReqValid, bReqAddr, 32'(i * 4));
        end
      end
      if (i >= 2) begin
        checks++;
        if ((bInstValid !== 1'b1) || (bInstPc !== 32'((i - 2) * 4)) ||
            (bInstData !== memData(32'((i - 2) * 4)))) begin
          errors++;
          $display("[TB] FAIL reset_seq_inst[%0d]: got valid=%b pc=%h data=%h, expected valid=1 pc=%h data=%h",
                   i, bInstValid, bInstPc, bInstData, 32'((i - 2) * 4), memData(32'((i - 2) * 4)));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] expW [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    doReset();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (i < 4) begin
        if ((wReqValid !== 1'b1) || (wReqAddr !== expW[i])) begin
          errors++;
          $display("[TB] FAIL wrap_addr[%0d]: got valid=%b addr=%h, expected valid=1 addr=%h",
                   i, wReqValid, wReqAddr, expW[i]);
        end
      end else if ((wReqValid !== 1'b0) || (wInstValid !== 1'b0) ||
                   (wInstData !== 32'h0) || (wInstPc !== 32'h0)) begin
        errors++;
        $display("[TB] FAIL wrap_full_stall: got req=%b inst=%b data=%h pc=%h, expected 0/0/0/0",
                 wReqValid, wInstValid, wInstData, wInstPc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int reqs = 0;
    aInstReady = 1'b0;
    aHold      = 1'b0;
    doReset();
    for (int i = 0; i < 8; i++) begin
      #1;
      if (aReqValid && aReqReady) reqs++;
      @(negedge clk);
    end
    checks++;
    if (reqs != 2) begin
      errors++;
      $display("[TB] FAIL bp_request_count: got %0d, expected 2", reqs);
    end
    #1;
    checks++;
    if ((aReqValid !== 1'b0) || (aInstValid !== 1'b1) || (aInstPc !== 32'h0)) begin
      errors++;
      $display("[TB] FAIL bp_stalled: got req=%b inst=%b pc=%h, expected req=0 inst=1 pc=0",
               aReqValid, aInstValid, aInstPc);
    end
    aInstReady = 1'b1;
    @(negedge clk);
    aInstReady = 1'b0;
    #1;
    checks++;
    if ((aReqValid !== 1'b1) || (aReqAddr !== 32'h8) || (aInstPc !== 32'h4)) begin
      errors++;
      $display("[TB] FAIL bp_after_pop: got req=%b addr=%h pc=%h, expected req=1 addr=8 pc=4",
               aReqValid, aReqAddr, aInstPc);
    end
  endtask

  task automatic test_redirect();
    aInstReady = 1'b0;
    aHold      = 1'b1;
    doReset();
    repeat (4) @(negedge clk);
    aRedirValid = 1'b1;
    aRedirPc    = 32'h100;
    @(negedge clk);
    aRedirValid = 1'b0;
    aHold       = 1'b0;
    aInstReady  = 1'b1;
    collectInsts(2, 30);
    checks++;
    if (gotPc.size() != 2) begin
      errors++;
      $display("[TB] FAIL redirect_inst_count: got %0d, expected 2", gotPc.size());
    end else begin
      checks++;
      if ((gotPc[0] !== 32'h100) || (gotData[0] !== memData(32'h100))) begin
        errors++;
        $display("[TB] FAIL redirect_first: got pc=%h data=%h, expected pc=100 data=%h",
                 gotPc[0], gotData[0], memData(32'h100));
      end
      checks++;
      if (gotPc[1] !== 32'h104) begin
        errors++;
        $display("[TB] FAIL redirect_second: got pc=%h, expected 104", gotPc[1]);
      end
    end
  endtask

  task automatic test_misaligned();
    bit seen = 0;
    aInstReady = 1'b1;
    aHold      = 1'b0;
    doReset();
    repeat (3) @(negedge clk);
    aRedirValid = 1'b1;
    aRedirPc    = 32'h203;
    #1;
    checks++;
    if (aReqValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL misaligned_req_during_redirect: got %b, expected 0", aReqValid);
    end
    @(negedge clk);
    aRedirValid = 1'b0;
    for (int c = 0; (c < 10) && !seen; c++) begin
      #1;
      if (aReqValid) begin
        seen = 1;
        checks++;
        if (aReqAddr !== 32'h200) begin
          errors++;
          $display("[TB] FAIL misaligned_addr: got %h, expected 200", aReqAddr);
        end
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL misaligned_timeout: got no request, expected addr 200");
    end
  endtask

  task automatic test_simultaneous();
    bit found = 0;
    aInstReady = 1'b1;
    aHold      = 1'b0;
    doReset();
    for (int c = 0; (c < 20) && !found; c++) begin
      #1;
      if (aRspValid && aInstValid) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL simul_setup: got no cycle with rsp and inst valid, expected one");
    end else begin
      aRedirValid = 1'b1;
      aRedirPc    = 32'h300;
      @(negedge clk);
      aRedirValid = 1'b0;
      #1;
      checks++;
      if (aInstValid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL simul_flush: got inst_valid=%b pc=%h, expected inst_valid=0", aInstValid, aInstPc);
      end
      @(negedge clk);
      collectInsts(1, 20);
      checks++;
      if ((gotPc.size() != 1) || (gotPc[0] !== 32'h300)) begin
        errors++;
        $display("[TB] FAIL simul_next_pc: got count=%0d pc=%h, expected count=1 pc=300",
                 gotPc.size(), (gotPc.size() != 0) ? gotPc[0] : 32'h0);
      end
    end
  endtask

  task automatic test_back_to_back();
    aInstReady = 1'b0;
    aHold      = 1'b1;
    doReset();
    repeat (4) @(negedge clk);
    aRedirValid = 1'b1;
    aRedirPc    = 32'h400;
    @(negedge clk);
    aRedirPc    = 32'h500;
    @(negedge clk);
    aRedirValid = 1'b0;
    aHold       = 1'b0;
    aInstReady  = 1'b1;
    collectInsts(2, 30);
    checks++;
    if ((gotPc.size() != 2) || (gotPc[0] !== 32'h500) || (gotPc[1] !== 32'h504)) begin
      errors++;
      $display("[TB] FAIL b2b_redirect: got count=%0d pc0=%h pc1=%h, expected count=2 pc0=500 pc1=504",
               gotPc.size(), (gotPc.size() > 0) ? gotPc[0] : 32'h0, (gotPc.size() > 1) ? gotPc[1] : 32'h0);
    end
  endtask

  initial begin
    aReqReady   = 1'b1;
    aRedirValid = 1'b0;
    aRedirPc    = '0;
    aInstReady  = 1'b0;
    aHold       = 1'b0;
    bReqReady   = 1'b1;
    bInstReady  = 1'b0;
    test_reset();
    test_wrap();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_simultaneous();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
